// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// bit-counter sizing.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    localparam int unsigned CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational 1-bit full subtractor cell: Diff = A - B - Bin, Bout = borrow out.
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic Diff,
    output logic Bout
);

    always_comb begin
        Diff = A ^ B ^ Bin;
        Bout = (~A & B) | (~(A ^ B) & Bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor Diff = A - B - Bin with Start/Busy/Done handshake.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output Ovf.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-2:0] acc;
    logic [WIDTH-1:0] acc_ext;
    logic             borrow_q;
    logic [CW-1:0]    cnt_q;
    logic             d_bit, w_next;
    logic             load, last;

`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb, b_msb;
`endif

    full_subtractor u_fs (
        .A    (a_sh[0]),
        .B    (b_sh[0]),
        .Bin  (borrow_q),
        .Diff (d_bit),
        .Bout (w_next)
    );

    // acc keeps only the WIDTH-1 bits that survive the next shift; the
    // incoming bit on top completes the full-width result.
    assign acc_ext = {d_bit, acc};

    always_comb begin
        load = Start && ((state_q == IDLE) || (state_q == DONE));
        last = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        Busy    = 1'b0;
        Done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) state_d = SHIFT;
            end
            SHIFT: begin
                Busy = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                Done    = 1'b1;
                state_d = Start ? SHIFT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            acc      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            Diff     <= '0;
            Bout     <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            Ovf      <= 1'b0;
`endif
        end else if (load) begin
            a_sh     <= A;
            b_sh     <= B;
            acc      <= '0;
            borrow_q <= Bin;
            cnt_q    <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb    <= A[WIDTH-1];
            b_msb    <= B[WIDTH-1];
`endif
        end else if (state_q == SHIFT) begin
            a_sh     <= a_sh >> 1;
            b_sh     <= b_sh >> 1;
            acc      <= acc_ext[WIDTH-1:1];
            borrow_q <= w_next;
            cnt_q    <= cnt_q + 1'b1;
            if (last) begin
                Diff <= acc_ext;
                Bout <= w_next;
`ifdef SERIAL_SUB_OVF_EN
                Ovf  <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         Start = 1'b0;
    logic [W-1:0] A = '0, B = '0;
    logic         Bin = 1'b0;
    logic         Busy, Done, Bout;
    logic [W-1:0] Diff;
`ifdef SERIAL_SUB_OVF_EN
    logic         Ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Start (Start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .Busy  (Busy),
        .Done  (Done),
        .Diff  (Diff),
        .Bout  (Bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .Ovf   (Ovf)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Launch one operation (called #1 after a rising edge, in IDLE or DONE)
    // and return once Done is seen or the cycle budget runs out.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         output int lat, output int busy_n);
        A = a; B = b; Bin = bin; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        lat = 1; busy_n = 0;
        while (!Done && lat < 20) begin
            if (Busy) busy_n++;
            @(posedge Clk); #1;
            lat++;
        end
    endtask

    task automatic op_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic bin, input logic [W-1:0] exp_d, input logic exp_b,
                            input logic exp_ovf);
        int lat, busy_n;
        do_op(a, b, bin, lat, busy_n);
        check({tag, "_lat"}, lat, 9);
        check({tag, "_diff"}, Diff, exp_d);
        check({tag, "_bout"}, Bout, exp_b);
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf"}, Ovf, exp_ovf);
`else
        if (exp_ovf === 1'bx) check({tag, "_ovfx"}, 0, 1);
`endif
    endtask

    initial begin : main
        int lat, busy_n, dones;
        logic [W:0]   full;
        logic [W-1:0] ra, rb;
        logic         rbin;

        #12;
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_diff", Diff, 0);
        check("rst_bout", Bout, 0);
        Rst = 1'b0;
        @(posedge Clk); #1;

        // Basic operation with latency and Busy-length checks
        do_op(8'h35, 8'h12, 1'b0, lat, busy_n);
        check("t1_lat", lat, 9);
        check("t1_busy", busy_n, 8);
        check("t1_diff", Diff, 8'h23);
        check("t1_bout", Bout, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("t1_ovf", Ovf, 0);
`endif
        @(posedge Clk); #1;
        check("t1_done_pulse", Done, 0);
        check("t1_hold", Diff, 8'h23);

        op_check("t2", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        op_check("t3", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
        op_check("t4", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        op_check("t5", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        @(posedge Clk); #1;

        // Start pulsed mid-SHIFT must be ignored
        A = 8'h35; B = 8'h12; Bin = 1'b0; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        A = 8'hAA; B = 8'h55; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        dones = 0; lat = 0;
        while (!Done && lat < 20) begin
            @(posedge Clk); #1;
            lat++;
        end
        check("mid_lat", lat, 4);
        check("mid_diff", Diff, 8'h23);
        check("mid_bout", Bout, 0);
        // Back-to-back: Start issued in the Done cycle
        do_op(8'hAA, 8'h55, 1'b0, lat, busy_n);
        check("b2b_lat", lat, 9);
        check("b2b_busy", busy_n, 8);
        check("b2b_diff", Diff, 8'h55);
        check("b2b_bout", Bout, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("b2b_ovf", Ovf, 1);
`endif
        repeat (3) begin
            @(posedge Clk); #1;
            if (Done) dones++;
        end
        check("no_extra_done", dones, 0);

        // Asynchronous reset 4 cycles into an operation
        A = 8'h35; B = 8'h12; Bin = 1'b0; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        Rst = 1'b1;
        #1;
        check("arst_busy", Busy, 0);
        check("arst_done", Done, 0);
        check("arst_diff", Diff, 0);
        check("arst_bout", Bout, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("arst_ovf", Ovf, 0);
`endif
        @(negedge Clk);
        Rst = 1'b0;
        dones = 0;
        repeat (12) begin
            @(posedge Clk); #1;
            if (Done || Busy) dones++;
        end
        check("arst_no_done", dones, 0);
        check("arst_diff_hold", Diff, 0);
        op_check("post_rst", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0);

        // Random operations against the 9-bit reference subtraction
        for (int i = 0; i < 1000; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom);
            full = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
            if ($urandom_range(0, 3) == 0) begin
                @(posedge Clk); #1;
            end
            op_check("rnd", ra, rb, rbin, full[W-1:0], full[W],
                     (ra[W-1] ^ rb[W-1]) & (full[W-1] ^ ra[W-1]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
